cpu_bus_serdes: RTL and testbench
=================================

Name: cpu_bus_serdes

Overview:
- Parametrised bridge between the CPU core's wide address/data bus and the narrow chip pins.
- Accepts one CPU transaction (read or write) and emits it over PIN_W-wide pins as a beat sequence: header beat, address beats, then write-data beats.
- Reads perform a bus turnaround and gather read-data beats back into a DATA_W word.
- Adds a pin-side flow-control input (pin_ready) and a CPU-side req/ack handshake.

Parameters:
- ADDR_W, 32: CPU address width. Must be an integer multiple of PIN_W.
- DATA_W, 32: CPU data width. Must be an integer multiple of PIN_W.
- PIN_W, 8: pin bus width per beat.
- MSB_FIRST, 0: beat order. 0 = least-significant slice first; 1 = most-significant slice first.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous active-high reset
- cpu_req  in  1  transaction request, sampled in IDLE
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  transaction address
- cpu_wdata  in  DATA_W  write data
- cpu_busy  out  1  high whenever the FSM is not in IDLE
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rdata  out  DATA_W  last completed read word
- pin_out  out  PIN_W  outbound beat
- pin_oe  out  PIN_W  pin output enable, all-ones or all-zeros
- pin_in  in  PIN_W  inbound beat
- pin_ready  in  1  external side accepts/presents the current beat
- pin_frame  out  1  high during the header beat
- pin_last  out  1  high during the final data beat of a transaction

Behaviour:
- Derived constants: A = ADDR_W/PIN_W beats; D = DATA_W/PIN_W beats. The beat counter is clog2(max(A,D)) bits wide.
- Reset (asynchronous, any state):
  - FSM goes to IDLE; beat counter and latched request are cleared.
  - cpu_rdata = 0; all other outputs = 0.
  - A transaction in flight is abandoned, with no ack.
- IDLE:
  - cpu_busy = 0.
  - On a rising edge with cpu_req = 1: latch cpu_we, cpu_addr and cpu_wdata, then go to HDR.
  - CPU inputs are ignored from then until return to IDLE; a cpu_req held high does not re-trigger until IDLE is re-entered.
- HDR:
  - pin_out[0] = latched we, all other pin_out bits = 0; pin_oe = all ones; pin_frame = 1.
  - Advances to ADDR on an edge with pin_ready = 1; otherwise holds.
- ADDR:
  - pin_out = address slice k, with pin_oe = all ones.
  - Slice k = bits [k*PIN_W +: PIN_W], where k counts 0..A-1 if MSB_FIRST = 0, or A-1..0 if MSB_FIRST = 1. Slices never overlap.
  - The counter increments only when pin_ready = 1.
  - After the last address beat is accepted: go to WDATA if we, otherwise TURN.
- WDATA:
  - Drives D write-data slices, same ordering and pin_ready rules as ADDR.
  - pin_last = 1 on slice D-1 (order-wise).
  - When the last beat is accepted, go to DONE.
- TURN:
  - Exactly one cycle; pin_oe = 0, pin_out = 0. pin_ready is ignored.
  - Goes to RDATA.
- RDATA:
  - pin_oe = 0.
  - On each edge with pin_ready = 1, capture pin_in into slice k of an internal shift/assembly register, then increment k.
  - pin_last = 1 during the final beat.
  - After D captured beats, go to DONE.
- DONE:
  - cpu_ack = 1 for exactly one cycle, then IDLE.
  - For reads, cpu_rdata is updated on the edge entering DONE and holds until the next read completes.
  - Writes never modify cpu_rdata.
- Default output values: pin_out = 0 in IDLE, TURN, RDATA and DONE; pin_frame and pin_last = 0 outside the cases above.
- Latency with pin_ready tied high (edges counted after the accept edge; ack is high in the following cycle):
  - Write: 1 + A + D edges (9 for defaults).
  - Read: 2 + A + D edges (10 for defaults).
  - Each low cycle of pin_ready adds exactly one cycle, except in TURN and DONE.
- No back-to-back overlap: the earliest next accept is the edge after DONE, because IDLE lasts at least one cycle.

Test Plan:
1. Write with defaults: cpu_addr = 0x12345678, cpu_wdata = 0xCAFEBABE, pin_ready = 1. Required: pin_out sequence 01, 78, 56, 34, 12, BE, BA, FE, CA; pin_frame on beat 1 only; pin_last on CA; cpu_ack 9 edges after accept; cpu_rdata unchanged.
2. Read with defaults: cpu_addr = 0x000000A5, pin_in supplies 11, 22, 33, 44 during RDATA. Required: header 00, then A5 00 00 00; one TURN cycle with pin_oe = 0; cpu_rdata = 0x44332211 with ack 10 edges after accept.
3. Flow control: same write as scenario 1 with pin_ready low for 3 cycles during address beat 2. Required: pin_out holds 0x34 for 4 cycles; ack is delayed by exactly 3 cycles.
4. MSB_FIRST = 1 read: pin_in supplies 44, 33, 22, 11. Required: cpu_rdata = 0x44332211; address beats are driven MSB slice first.
5. Reset mid-read, asserted during RDATA beat 2: outputs are immediately 0, cpu_rdata = 0, FSM is IDLE with no ack. A new request after deassertion completes normally.
6. Parametrised instance with ADDR_W = 16, DATA_W = 8, PIN_W = 4: write 0xBEEF / 0x5A. Required: beats 1, F, E, E, B, A, 5; ack 7 edges after accept. cpu_req held high through ack re-triggers only after IDLE.

Source files
------------

// File: rtl/cpu_bus_serdes.sv
// cpu_bus_serdes: serialises one CPU read/write into PIN_W-wide pin beats
// (header, address, write data) and gathers read-data beats back into a word.
module cpu_bus_serdes #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int PIN_W     = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_busy,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic [PIN_W-1:0]  pin_out,
  output logic [PIN_W-1:0]  pin_oe,
  input  logic [PIN_W-1:0]  pin_in,
  input  logic              pin_ready,
  output logic              pin_frame,
  output logic              pin_last
);

  localparam int A    = ADDR_W / PIN_W;
  localparam int D    = DATA_W / PIN_W;
  localparam int NMAX = (A > D) ? A : D;
  localparam int CW   = (NMAX > 1) ? $clog2(NMAX) : 1;

  localparam logic [CW-1:0] A_LAST = CW'(A - 1);
  localparam logic [CW-1:0] D_LAST = CW'(D - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_ADDR,
    S_WDATA,
    S_TURN,
    S_RDATA,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [CW-1:0]     cnt, cnt_nxt;
  logic [CW-1:0]     a_idx, d_idx;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] asm_q, asm_nxt;
  logic              capture;

  // Beat order: the counter always runs upward, the slice index may run down.
  assign a_idx = MSB_FIRST ? (A_LAST - cnt) : cnt;
  assign d_idx = MSB_FIRST ? (D_LAST - cnt) : cnt;

  always_comb begin
    asm_nxt = asm_q;
    asm_nxt[d_idx*PIN_W +: PIN_W] = pin_in;
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pin_out   = '0;
    pin_oe    = '0;
    pin_frame = 1'b0;
    pin_last  = 1'b0;
    cpu_ack   = 1'b0;
    cpu_busy  = (state != S_IDLE);
    capture   = 1'b0;
    unique case (state)
      S_IDLE: begin
        cnt_nxt = '0;
        if (cpu_req) state_nxt = S_HDR;
      end
      S_HDR: begin
        pin_out   = PIN_W'(we_q);
        pin_oe    = '1;
        pin_frame = 1'b1;
        if (pin_ready) begin
          state_nxt = S_ADDR;
          cnt_nxt   = '0;
        end
      end
      S_ADDR: begin
        pin_out = addr_q[a_idx*PIN_W +: PIN_W];
        pin_oe  = '1;
        if (pin_ready) begin
          if (cnt == A_LAST) begin
            cnt_nxt   = '0;
            state_nxt = we_q ? S_WDATA : S_TURN;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      S_WDATA: begin
        pin_out  = wdata_q[d_idx*PIN_W +: PIN_W];
        pin_oe   = '1;
        pin_last = (cnt == D_LAST);
        if (pin_ready) begin
          if (cnt == D_LAST) begin
            cnt_nxt   = '0;
            state_nxt = S_DONE;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      S_TURN: begin
        cnt_nxt   = '0;
        state_nxt = S_RDATA;
      end
      S_RDATA: begin
        pin_last = (cnt == D_LAST);
        if (pin_ready) begin
          capture = 1'b1;
          if (cnt == D_LAST) begin
            cnt_nxt   = '0;
            state_nxt = S_DONE;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      S_DONE: begin
        cpu_ack   = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (state == S_IDLE && cpu_req) begin
      we_q    <= cpu_we;
      addr_q  <= cpu_addr;
      wdata_q <= cpu_wdata;
    end
  end

  // The final beat goes straight into cpu_rdata on the edge entering DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      asm_q     <= '0;
      cpu_rdata <= '0;
    end else if (capture) begin
      asm_q <= asm_nxt;
      if (cnt == D_LAST) cpu_rdata <= asm_nxt;
    end
  end

endmodule

// File: tb/tb_cpu_bus_serdes.sv
// Directed testbench for cpu_bus_serdes: default, MSB-first and
// narrow-pin instances driven by hand-computed beat sequences.
module tb_cpu_bus_serdes;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, req0, req1, req2, we, rdy;
  logic [31:0] addr, wdata;
  logic [7:0]  pin_in;
  logic [15:0] addr2;
  logic [7:0]  wdata2;
  logic [3:0]  pin_in2;

  logic        busy0, ack0, frame0, last0;
  logic [31:0] rdata0;
  logic [7:0]  pout0, oe0;
  logic        busy1, ack1, frame1, last1;
  logic [31:0] rdata1;
  logic [7:0]  pout1, oe1;
  logic        busy2, ack2, frame2, last2;
  logic [7:0]  rdata2;
  logic [3:0]  pout2, oe2;

  int checks = 0;
  int failures = 0;
  int n;

  logic [7:0] wexp [9]  = '{8'h01, 8'h78, 8'h56, 8'h34, 8'h12,
                            8'hBE, 8'hBA, 8'hFE, 8'hCA};
  logic [7:0] rexp [5]  = '{8'h00, 8'hA5, 8'h00, 8'h00, 8'h00};
  logic [7:0] rd_in [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic [7:0] sexp [12] = '{8'h01, 8'h78, 8'h56, 8'h34, 8'h34, 8'h34,
                            8'h34, 8'h12, 8'hBE, 8'hBA, 8'hFE, 8'hCA};
  logic [7:0] mexp [5]  = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hA5};
  logic [7:0] rd_msb [4] = '{8'h44, 8'h33, 8'h22, 8'h11};
  logic [3:0] pexp [7]  = '{4'h1, 4'hF, 4'hE, 4'hE, 4'hB, 4'hA, 4'h5};

  cpu_bus_serdes u0 (
    .clk(clk), .rst(rst), .cpu_req(req0), .cpu_we(we),
    .cpu_addr(addr), .cpu_wdata(wdata), .cpu_busy(busy0),
    .cpu_ack(ack0), .cpu_rdata(rdata0), .pin_out(pout0),
    .pin_oe(oe0), .pin_in(pin_in), .pin_ready(rdy),
    .pin_frame(frame0), .pin_last(last0)
  );

  cpu_bus_serdes #(.MSB_FIRST(1'b1)) u1 (
    .clk(clk), .rst(rst), .cpu_req(req1), .cpu_we(we),
    .cpu_addr(addr), .cpu_wdata(wdata), .cpu_busy(busy1),
    .cpu_ack(ack1), .cpu_rdata(rdata1), .pin_out(pout1),
    .pin_oe(oe1), .pin_in(pin_in), .pin_ready(rdy),
    .pin_frame(frame1), .pin_last(last1)
  );

  cpu_bus_serdes #(.ADDR_W(16), .DATA_W(8), .PIN_W(4)) u2 (
    .clk(clk), .rst(rst), .cpu_req(req2), .cpu_we(we),
    .cpu_addr(addr2), .cpu_wdata(wdata2), .cpu_busy(busy2),
    .cpu_ack(ack2), .cpu_rdata(rdata2), .pin_out(pout2),
    .pin_oe(oe2), .pin_in(pin_in2), .pin_ready(rdy),
    .pin_frame(frame2), .pin_last(last2)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; req0 = 0; req1 = 0; req2 = 0; we = 0; rdy = 1;
    addr = '0; wdata = '0; pin_in = '0;
    addr2 = '0; wdata2 = '0; pin_in2 = '0;
    cyc(); cyc();
    chk("rst_outs", {busy0, ack0, frame0, last0, oe0, pout0}, 0);
    chk("rst_rdata", rdata0, 0);
    rst = 1'b0;
    cyc();

    // write, pin_ready high
    we = 1; addr = 32'h12345678; wdata = 32'hCAFEBABE; req0 = 1;
    cyc();
    req0 = 0;
    for (int i = 0; i < 9; i++) begin
      chk("t1_pout", pout0, wexp[i]);
      chk("t1_oe", oe0, 8'hFF);
      chk("t1_frame", frame0, (i == 0));
      chk("t1_last", last0, (i == 8));
      chk("t1_noack", ack0, 0);
      cyc();
    end
    chk("t1_ack", ack0, 1);
    chk("t1_rdata", rdata0, 0);
    cyc();
    chk("t1_idle", {busy0, ack0}, 0);

    // read, defaults
    we = 0; addr = 32'h000000A5; req0 = 1;
    cyc();
    req0 = 0;
    for (int i = 0; i < 5; i++) begin
      chk("t2_pout", pout0, rexp[i]);
      chk("t2_oe", oe0, 8'hFF);
      cyc();
    end
    chk("t2_turn", {oe0, pout0}, 0);
    chk("t2_turn_busy", busy0, 1);
    cyc();
    for (int i = 0; i < 4; i++) begin
      pin_in = rd_in[i];
      chk("t2_rd_oe", {oe0, pout0}, 0);
      chk("t2_rd_last", last0, (i == 3));
      chk("t2_noack", ack0, 0);
      cyc();
    end
    chk("t2_ack", ack0, 1);
    chk("t2_rdata", rdata0, 32'h44332211);
    cyc();

    // write with 3-cycle stall on address beat 0x34
    we = 1; addr = 32'h12345678; wdata = 32'hCAFEBABE; req0 = 1;
    cyc();
    req0 = 0;
    for (int i = 0; i < 12; i++) begin
      rdy = !(i >= 3 && i <= 5);
      chk("t3_pout", pout0, sexp[i]);
      chk("t3_noack", ack0, 0);
      cyc();
    end
    rdy = 1;
    chk("t3_ack", ack0, 1);
    chk("t3_rdata", rdata0, 32'h44332211);
    cyc();

    // MSB-first read
    we = 0; addr = 32'h000000A5; req1 = 1;
    cyc();
    req1 = 0;
    for (int i = 0; i < 5; i++) begin
      chk("t4_pout", pout1, mexp[i]);
      cyc();
    end
    chk("t4_turn", oe1, 0);
    cyc();
    for (int i = 0; i < 4; i++) begin
      pin_in = rd_msb[i];
      chk("t4_last", last1, (i == 3));
      cyc();
    end
    chk("t4_ack", ack1, 1);
    chk("t4_rdata", rdata1, 32'h44332211);
    cyc();

    // reset during RDATA beat 2
    we = 0; addr = 32'h00000005; req0 = 1;
    cyc();
    req0 = 0;
    repeat (6) cyc();
    pin_in = 8'hAA; cyc();
    pin_in = 8'hBB; cyc();
    chk("t5_pre_busy", busy0, 1);
    chk("t5_pre_rdata", rdata0, 32'h44332211);
    rst = 1'b1;
    #1;
    chk("t5_rst_outs", {busy0, ack0, frame0, last0, oe0, pout0}, 0);
    chk("t5_rst_rdata", rdata0, 0);
    cyc();
    chk("t5_rst_noack", ack0, 0);
    #2 rst = 1'b0;
    cyc();
    req0 = 1;
    cyc();
    req0 = 0;
    n = 0;
    while (!ack0 && n < 30) begin
      pin_in = 8'h3C;
      cyc();
      n++;
    end
    chk("t5_lat", n, 10);
    chk("t5_rdata", rdata0, 32'h3C3C3C3C);
    cyc();

    // narrow instance, cpu_req held high
    we = 1; addr2 = 16'hBEEF; wdata2 = 8'h5A; req2 = 1;
    cyc();
    for (int i = 0; i < 7; i++) begin
      chk("t6_pout", pout2, pexp[i]);
      chk("t6_oe", oe2, 4'hF);
      chk("t6_last", last2, (i == 6));
      chk("t6_noack", ack2, 0);
      cyc();
    end
    chk("t6_ack", ack2, 1);
    chk("t6_busy_done", busy2, 1);
    cyc();
    chk("t6_idle", {busy2, ack2}, 0);
    cyc();
    chk("t6_retrig", {busy2, frame2, pout2}, 6'b11_0001);
    req2 = 0;
    n = 0;
    while (busy2 && n < 30) begin
      cyc();
      n++;
    end
    chk("t6_drain", n, 8);
    chk("t6_rdata", rdata2, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
